// File: rtl/cu_io_arbiter.sv
// Round-robin, time-multiplexed owner of the chip-top output pins for two compute units.
// One unit drives uo_out/uio_out/uio_oe at a time, with bounded hold and a one-cycle turnaround.
module cu_io_arbiter #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [1:0] req,
    input  logic [7:0] cu0_uo,
    input  logic [7:0] cu0_uio_out,
    input  logic [7:0] cu0_uio_oe,
    input  logic [7:0] cu1_uo,
    input  logic [7:0] cu1_uio_out,
    input  logic [7:0] cu1_uio_oe,
    output logic [1:0] gnt,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;
    localparam logic [1:0] TURN = 2'd3;

    localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

    logic [1:0] state_q, state_d;
    logic [1:0] gnt_q, gnt_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;
    logic       last_q, last_d;

    // IDLE and TURN arbitrate identically; on a tie the unit that did not own last wins.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        hold_cnt_d = hold_cnt_q;
        last_d     = last_q;
        if (ena) begin
            case (state_q)
                IDLE, TURN: begin
                    state_d    = IDLE;
                    gnt_d      = 2'b00;
                    hold_cnt_d = 4'd0;
                    if ((req[0] && !req[1]) || (req == 2'b11 && last_q)) begin
                        state_d    = OWN0;
                        gnt_d      = 2'b01;
                        hold_cnt_d = 4'd1;
                    end else if (req[1]) begin
                        state_d    = OWN1;
                        gnt_d      = 2'b10;
                        hold_cnt_d = 4'd1;
                    end
                end
                OWN0: begin
                    if (!req[0] || (hold_cnt_q == HOLD_LIM && req[1])) begin
                        state_d    = TURN;
                        gnt_d      = 2'b00;
                        hold_cnt_d = 4'd0;
                        last_d     = 1'b0;
                    end else if (hold_cnt_q != HOLD_LIM) begin
                        hold_cnt_d = hold_cnt_q + 4'd1;
                    end
                end
                OWN1: begin
                    if (!req[1] || (hold_cnt_q == HOLD_LIM && req[0])) begin
                        state_d    = TURN;
                        gnt_d      = 2'b00;
                        hold_cnt_d = 4'd0;
                        last_d     = 1'b1;
                    end else if (hold_cnt_q != HOLD_LIM) begin
                        hold_cnt_d = hold_cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    gnt_d      = 2'b00;
                    hold_cnt_d = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= 2'b00;
            hold_cnt_q <= 4'd0;
            last_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            hold_cnt_q <= hold_cnt_d;
            last_q     <= last_d;
        end
    end

    // The ungranted unit is never merged in; no owner drives all zeros.
    always_comb begin
        uo_out  = 8'h00;
        uio_out = 8'h00;
        uio_oe  = 8'h00;
        case (gnt_q)
            2'b01: begin
                uo_out  = cu0_uo;
                uio_out = cu0_uio_out;
                uio_oe  = cu0_uio_oe;
            end
            2'b10: begin
                uo_out  = cu1_uo;
                uio_out = cu1_uio_out;
                uio_oe  = cu1_uio_oe;
            end
            default: begin
                uo_out  = 8'h00;
                uio_out = 8'h00;
                uio_oe  = 8'h00;
            end
        endcase
    end

    assign gnt = gnt_q;

    // Owner switches must always pass through an all-zero grant.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert ($onehot0(gnt_q));
            assert (!((gnt_q != 2'b00) && (gnt_d != 2'b00) && (gnt_d != gnt_q)));
        end
    end

endmodule

// File: tb/tb_cu_io_arbiter.sv
// Scoreboard bench for cu_io_arbiter: a behavioural model predicts each cycle's grant and pin values.
module tb_cu_io_arbiter;

   localparam int HOLD = 8;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [1:0] req;
   logic [7:0] cu0_uo, cu0_uio_out, cu0_uio_oe;
   logic [7:0] cu1_uo, cu1_uio_out, cu1_uio_oe;
   logic [1:0] gnt;
   logic [7:0] uo_out, uio_out, uio_oe;

   int checkCount = 0;
   int passCount  = 0;

   // Model state: owner -1 means nobody owns the pins (idle or turnaround).
   int mOwner = -1;
   int mCnt   = 0;
   int mLast  = 1;

   logic [25:0] expQueue[$];

   cu_io_arbiter #(.HOLD_MAX(HOLD)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .ena(ena),
      .req(req),
      .cu0_uo(cu0_uo),
      .cu0_uio_out(cu0_uio_out),
      .cu0_uio_oe(cu0_uio_oe),
      .cu1_uo(cu1_uo),
      .cu1_uio_out(cu1_uio_out),
      .cu1_uio_oe(cu1_uio_oe),
      .gnt(gnt),
      .uo_out(uo_out),
      .uio_out(uio_out),
      .uio_oe(uio_oe)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Every comparison in the bench is routed through here.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Advance the model by one rising edge using the inputs currently on the pins.
   task automatic stepModel();
      int pick;
      int other;
      if (!rst_n) begin
         mOwner = -1;
         mCnt   = 0;
         mLast  = 1;
      end else if (ena) begin
         if (mOwner < 0) begin
            pick = -1;
            if (req == 2'b11)     pick = 1 - mLast;
            else if (req[0])      pick = 0;
            else if (req[1])      pick = 1;
            mOwner = pick;
            mCnt   = (pick >= 0) ? 1 : 0;
         end else begin
            other = 1 - mOwner;
            if (!req[mOwner] || (mCnt == HOLD && req[other])) begin
               mLast  = mOwner;
               mOwner = -1;
               mCnt   = 0;
            end else if (mCnt < HOLD) begin
               mCnt++;
            end
         end
      end
   endtask

   // Drive one cycle of inputs and push the prediction for the state after the next edge.
   task automatic applyStimulus(input logic r, input logic e, input logic [1:0] rq, input bit fixedData);
      logic [1:0] eg;
      logic [7:0] eu, eo, ee;
      rst_n = r;
      ena   = e;
      req   = rq;
      if (fixedData) begin
         cu0_uo      = 8'hA5;
         cu0_uio_out = 8'h3C;
         cu0_uio_oe  = 8'hFF;
      end else begin
         cu0_uo      = 8'($urandom);
         cu0_uio_out = 8'($urandom);
         cu0_uio_oe  = 8'($urandom);
      end
      cu1_uo      = 8'($urandom);
      cu1_uio_out = 8'($urandom);
      cu1_uio_oe  = 8'($urandom);
      stepModel();
      eg = 2'b00; eu = 8'h00; eo = 8'h00; ee = 8'h00;
      if (mOwner == 0) begin
         eg = 2'b01; eu = cu0_uo; eo = cu0_uio_out; ee = cu0_uio_oe;
      end else if (mOwner == 1) begin
         eg = 2'b10; eu = cu1_uo; eo = cu1_uio_out; ee = cu1_uio_oe;
      end
      expQueue.push_back({eg, eu, eo, ee});
   endtask

   // Wait for the edge, then compare the DUT against the oldest prediction.
   task automatic collectOutput(input string tag);
      logic [25:0] ex;
      @(posedge clk);
      #1;
      if (expQueue.size() == 0) begin
         checkOutput({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         ex = expQueue.pop_front();
         checkOutput({tag, "_gnt"},     32'(gnt),     32'(ex[25:24]));
         checkOutput({tag, "_uo_out"},  32'(uo_out),  32'(ex[23:16]));
         checkOutput({tag, "_uio_out"}, 32'(uio_out), 32'(ex[15:8]));
         checkOutput({tag, "_uio_oe"},  32'(uio_oe),  32'(ex[7:0]));
      end
   endtask

   task automatic runCycles(input string tag, input int n, input logic r, input logic e,
                            input logic [1:0] rq, input bit fixedData);
      for (int i = 0; i < n; i++) begin
         applyStimulus(r, e, rq, fixedData);
         collectOutput(tag);
      end
   endtask

   initial begin
      rst_n = 1'b0; ena = 1'b1; req = 2'b00;
      cu0_uo = 8'h00; cu0_uio_out = 8'h00; cu0_uio_oe = 8'h00;
      cu1_uo = 8'h00; cu1_uio_out = 8'h00; cu1_uio_oe = 8'h00;

      runCycles("reset", 2, 1'b0, 1'b1, 2'b11, 1'b0);
      checkOutput("reset_gnt_direct", 32'(gnt), 32'd0);

      // Single requester with known data; unit 1 data is random and must be ignored.
      runCycles("single0", 4, 1'b1, 1'b1, 2'b01, 1'b1);
      checkOutput("single0_uo_direct", 32'(uo_out), 32'hA5);
      runCycles("single0_drop", 3, 1'b1, 1'b1, 2'b00, 1'b0);

      // Both requesting from reset: unit 0 first, then alternation with turnarounds.
      runCycles("rr_reset", 1, 1'b0, 1'b1, 2'b00, 1'b0);
      runCycles("rr_both", 40, 1'b1, 1'b1, 2'b11, 1'b0);

      // Early release by unit 0, idle, then a one-cycle request pulse from unit 1.
      runCycles("drop_reset", 1, 1'b0, 1'b1, 2'b00, 1'b0);
      runCycles("drop_own0", 3, 1'b1, 1'b1, 2'b01, 1'b0);
      runCycles("drop_idle", 4, 1'b1, 1'b1, 2'b00, 1'b0);
      runCycles("pulse1", 1, 1'b1, 1'b1, 2'b10, 1'b0);
      checkOutput("pulse1_gnt_direct", 32'(gnt), 32'd2);
      runCycles("pulse1_after", 3, 1'b1, 1'b1, 2'b00, 1'b0);

      // Saturated hold, then a late competing request preempts on the next edge.
      runCycles("sat_own0", 20, 1'b1, 1'b1, 2'b01, 1'b0);
      runCycles("sat_preempt", 1, 1'b1, 1'b1, 2'b11, 1'b0);
      checkOutput("sat_turn_direct", 32'(gnt), 32'd0);
      runCycles("sat_handoff", 4, 1'b1, 1'b1, 2'b11, 1'b0);

      // Freeze during OWN1 with unit 0 pending, then resume.
      runCycles("frz_own1", 12, 1'b1, 1'b1, 2'b10, 1'b0);
      runCycles("frz_hold", 3, 1'b1, 1'b1, 2'b11, 1'b0);
      runCycles("frz_off", 5, 1'b1, 1'b0, 2'b11, 1'b0);
      runCycles("frz_resume", 14, 1'b1, 1'b1, 2'b11, 1'b0);

      // Reset in the middle of unit 1 ownership.
      runCycles("mid_own1", 4, 1'b1, 1'b1, 2'b10, 1'b0);
      checkOutput("mid_own1_direct", 32'(gnt), 32'd2);
      runCycles("mid_reset", 1, 1'b0, 1'b1, 2'b11, 1'b0);
      checkOutput("mid_reset_direct", 32'(uo_out | uio_out | uio_oe), 32'd0);
      runCycles("post_reset", 1, 1'b1, 1'b1, 2'b11, 1'b0);
      checkOutput("post_reset_gnt_direct", 32'(gnt), 32'd1);
      runCycles("post_reset_run", 12, 1'b1, 1'b1, 2'b11, 1'b0);

      // Randomised traffic with occasional freezes.
      for (int i = 0; i < 200; i++) begin
         runCycles("random", 1, 1'b1, ($urandom_range(0, 7) != 0), 2'($urandom), 1'b0);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
